proj_minhash_sketch: RTL and testbench

- Downstream consumer of the FM RAM read windows. Takes one K-byte genome window per beat, which is one k-mer in ASCII.
- Each window is 2-bit encoded and hashed multiplicatively, and the minimum hash over a segment of k-mers is tracked.
- At segment close, emits one MinHash sketch record: min hash, its position, beat count and an empty flag.
- Streaming only, with no backpressure. It matches the FM's one-window-per-cycle rate.

---
 rtl/proj_minhash_sketch_pkg.sv | 36 +++
 rtl/proj_minhash_sketch_if.sv | 40 ++++
 rtl/proj_minhash_encode.sv | 42 ++++
 rtl/proj_minhash_sketch.sv | 177 +++++++++++++++++
 tb/tb_proj_minhash_sketch.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/proj_minhash_sketch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : proj_minhash_sketch_pkg
// Purpose  : Shared constants and types for the MinHash sketch block:
//            default geometry, nucleotide codes, FSM state and record type.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package proj_minhash_sketch_pkg;

  localparam int                MH_K           = 16;
  localparam int                MH_DATA_BITS   = 8;
  localparam int                MH_HASH_BITS   = 16;
  localparam logic [2*MH_K-1:0] MH_HASH_MULT   = 32'h9E3779B1;
  localparam int                MH_SEGMENT_LEN = 64;
  localparam int                MH_POS_BITS    = $clog2(MH_SEGMENT_LEN);

  localparam logic [1:0] NT_A = 2'd0;
  localparam logic [1:0] NT_C = 2'd1;
  localparam logic [1:0] NT_G = 2'd2;
  localparam logic [1:0] NT_T = 2'd3;

  typedef enum logic [0:0] {
    MH_IDLE  = 1'b0,
    MH_ACCUM = 1'b1
  } mh_state_t;

  typedef struct packed {
    logic [MH_HASH_BITS-1:0] hash;
    logic [MH_POS_BITS-1:0]  pos;
    logic [MH_POS_BITS:0]    count;
    logic                    empty;
  } mh_sketch_t;

endpackage
`default_nettype wire

// File: rtl/proj_minhash_sketch_if.sv
`default_nettype none
// ============================================================================
// Module   : proj_minhash_sketch_if
// Purpose  : Streaming k-mer input and sketch-record output bundle.
// Ports    : in_valid/in_kmer/in_last   k-mer window stream (no backpressure)
//            out_valid                  one-cycle record strobe
//            out_min_hash/out_min_pos/out_count/out_empty  record fields
//            modport master drives the stream, modport slave is the sketcher.
// Revision : 1.0  initial release
// ============================================================================
interface proj_minhash_sketch_if
  import proj_minhash_sketch_pkg::*;
#(
  parameter int K         = MH_K,
  parameter int DATA_BITS = MH_DATA_BITS,
  parameter int HASH_BITS = MH_HASH_BITS,
  parameter int POS_BITS  = MH_POS_BITS
) ();

  logic                   in_valid;
  logic [K*DATA_BITS-1:0] in_kmer;
  logic                   in_last;
  logic                   out_valid;
  logic [HASH_BITS-1:0]   out_min_hash;
  logic [POS_BITS-1:0]    out_min_pos;
  logic [POS_BITS:0]      out_count;
  logic                   out_empty;

  modport master (
    output in_valid, in_kmer, in_last,
    input  out_valid, out_min_hash, out_min_pos, out_count, out_empty
  );

  modport slave (
    input  in_valid, in_kmer, in_last,
    output out_valid, out_min_hash, out_min_pos, out_count, out_empty
  );

endinterface
`default_nettype wire

// File: rtl/proj_minhash_encode.sv
`default_nettype none
// ============================================================================
// Module   : proj_minhash_encode
// Purpose  : Combinational ASCII nucleotide to 2-bit code (case-insensitive).
// Ports    : byte_i  genome byte
//            code_o  2-bit nucleotide code (A=0 C=1 G=2 T=3)
//            bad_o   byte is not one of ACGT/acgt
// Revision : 1.0  initial release
// ============================================================================
module proj_minhash_encode
  import proj_minhash_sketch_pkg::*;
#(
  parameter int DATA_BITS = MH_DATA_BITS
) (
  input  logic [DATA_BITS-1:0] byte_i,
  output logic [1:0]           code_o,
  output logic                 bad_o
);

  localparam logic [DATA_BITS-1:0] c_UA = DATA_BITS'(8'h41);
  localparam logic [DATA_BITS-1:0] c_UC = DATA_BITS'(8'h43);
  localparam logic [DATA_BITS-1:0] c_UG = DATA_BITS'(8'h47);
  localparam logic [DATA_BITS-1:0] c_UT = DATA_BITS'(8'h54);
  localparam logic [DATA_BITS-1:0] c_LA = DATA_BITS'(8'h61);
  localparam logic [DATA_BITS-1:0] c_LC = DATA_BITS'(8'h63);
  localparam logic [DATA_BITS-1:0] c_LG = DATA_BITS'(8'h67);
  localparam logic [DATA_BITS-1:0] c_LT = DATA_BITS'(8'h74);

  always_comb begin
    code_o = NT_A;
    bad_o  = 1'b0;
    case (byte_i)
      c_UA, c_LA: code_o = NT_A;
      c_UC, c_LC: code_o = NT_C;
      c_UG, c_LG: code_o = NT_G;
      c_UT, c_LT: code_o = NT_T;
      default:    bad_o  = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/proj_minhash_sketch.sv
`default_nettype none
// ============================================================================
// Module   : proj_minhash_sketch
// Purpose  : Streaming MinHash sketcher. Each beat is one K-byte k-mer; it is
//            2-bit encoded (S1), multiplicatively hashed (S2), and the minimum
//            hash over a segment is tracked (S3). One record per segment.
// Ports    : clk    clock
//            rst_n  synchronous active-low reset
//            bus    proj_minhash_sketch_if.slave (stream in, record out)
// Revision : 1.0  initial release
// ============================================================================
module proj_minhash_sketch
  import proj_minhash_sketch_pkg::*;
#(
  parameter int               K           = MH_K,
  parameter int               DATA_BITS   = MH_DATA_BITS,
  parameter int               HASH_BITS   = MH_HASH_BITS,
  parameter logic [2*K-1:0]   HASH_MULT   = MH_HASH_MULT,
  parameter int               SEGMENT_LEN = MH_SEGMENT_LEN,
  parameter int               POS_BITS    = $clog2(SEGMENT_LEN)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  proj_minhash_sketch_if.slave  bus
);

  localparam int                CNT_W     = POS_BITS + 1;
  localparam logic [CNT_W-1:0]  c_SEG_LEN = CNT_W'(SEGMENT_LEN);

  // ---------------- S1: encode ----------------
  logic [2*K-1:0] w_code;
  logic [K-1:0]   w_bad;

  for (genvar gi = 0; gi < K; gi++) begin : g_enc
    proj_minhash_encode #(.DATA_BITS(DATA_BITS)) u_enc (
      .byte_i (bus.in_kmer[gi*DATA_BITS +: DATA_BITS]),
      .code_o (w_code[2*gi +: 2]),
      .bad_o  (w_bad[gi])
    );
  end

  logic [2*K-1:0] s1_code_q;
  logic           s1_bad_q, s1_last_q, s1_valid_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_code_q  <= '0;
      s1_bad_q   <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_valid_q <= 1'b0;
    end else begin
      s1_code_q  <= w_code;
      s1_bad_q   <= |w_bad;
      s1_last_q  <= bus.in_last & bus.in_valid;
      s1_valid_q <= bus.in_valid;
    end
  end

  // ---------------- S2: hash ----------------
  // Product is kept at 2K bits (mod 2^2K); the hash is its top HASH_BITS.
  logic [2*K-1:0]       w_prod;
  logic [HASH_BITS-1:0] w_hash;
  assign w_prod = s1_code_q * HASH_MULT;
  assign w_hash = w_prod[2*K-1 -: HASH_BITS];

  if (HASH_BITS < 2*K) begin : g_prod_low
    logic w_unused_prod_low;
    assign w_unused_prod_low = ^w_prod[2*K-HASH_BITS-1:0];
  end

  logic [HASH_BITS-1:0] s2_hash_q;
  logic                 s2_bad_q, s2_last_q, s2_valid_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_hash_q  <= '0;
      s2_bad_q   <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      s2_hash_q  <= w_hash;
      s2_bad_q   <= s1_bad_q;
      s2_last_q  <= s1_last_q;
      s2_valid_q <= s1_valid_q;
    end
  end

  // ---------------- S3: min tracker FSM ----------------
  mh_state_t            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [HASH_BITS-1:0] min_q, min_d;
  logic [POS_BITS-1:0]  pos_q, pos_d;
  logic                 seen_q, seen_d;
  logic                 close_d;
  logic [CNT_W-1:0]     w_cnt_inc;

  assign w_cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    min_d   = min_q;
    pos_d   = pos_q;
    seen_d  = seen_q;
    close_d = 1'b0;
    case (state_q)
      MH_IDLE: begin
        if (s2_valid_q) begin
          cnt_d   = CNT_W'(1);
          min_d   = s2_bad_q ? '1 : s2_hash_q;
          pos_d   = '0;
          seen_d  = !s2_bad_q;
          close_d = s2_last_q;
          state_d = s2_last_q ? MH_IDLE : MH_ACCUM;
        end
      end
      MH_ACCUM: begin
        if (s2_valid_q) begin
          // Strict '<' keeps the earliest position on ties.
          if (!s2_bad_q && (!seen_q || (s2_hash_q < min_q))) begin
            min_d  = s2_hash_q;
            pos_d  = cnt_q[POS_BITS-1:0];
            seen_d = 1'b1;
          end
          cnt_d = w_cnt_inc;
          if (s2_last_q || (w_cnt_inc == c_SEG_LEN)) begin
            close_d = 1'b1;
            state_d = MH_IDLE;
          end
        end
      end
      default: state_d = MH_IDLE;
    endcase
  end

  logic                 out_valid_q, out_empty_q;
  logic [HASH_BITS-1:0] out_hash_q;
  logic [POS_BITS-1:0]  out_pos_q;
  logic [CNT_W-1:0]     out_count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= MH_IDLE;
      cnt_q       <= '0;
      min_q       <= '1;
      pos_q       <= '0;
      seen_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_hash_q  <= '1;
      out_pos_q   <= '0;
      out_count_q <= '0;
      out_empty_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      min_q       <= min_d;
      pos_q       <= pos_d;
      seen_q      <= seen_d;
      out_valid_q <= close_d;
      // Record fields hold their value until the next segment closes.
      if (close_d) begin
        out_hash_q  <= min_d;
        out_pos_q   <= pos_d;
        out_count_q <= cnt_d;
        out_empty_q <= !seen_d;
      end
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.out_min_hash = out_hash_q;
  assign bus.out_min_pos  = out_pos_q;
  assign bus.out_count    = out_count_q;
  assign bus.out_empty    = out_empty_q;

endmodule
`default_nettype wire

// File: tb/tb_proj_minhash_sketch.sv
`default_nettype none
// ============================================================================
// Module   : tb_proj_minhash_sketch
// Purpose  : Directed and random self-checking bench for proj_minhash_sketch.
// Ports    : none
// Revision : 1.0  initial release
// ============================================================================
module tb_proj_minhash_sketch;
  import proj_minhash_sketch_pkg::*;

  localparam logic [127:0] KM_A    = {16{8'h41}};
  localparam logic [127:0] KM_ACGT = "ACGTACGTACGTACGT";
  localparam logic [127:0] KM_N    = "ACGTNCGTACGTACGT";
  // Top 16 bits of (0x1B1B1B1B * 0x9E3779B1) mod 2^32, worked by hand.
  localparam logic [15:0]  H_ACGT  = 16'h0A5A;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   last_beat_cyc = 0;

  mh_sketch_t rec_q[$];
  int         rec_cyc_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  proj_minhash_sketch_if bus ();

  proj_minhash_sketch dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      rec_q.push_back('{hash: bus.out_min_hash, pos: bus.out_min_pos,
                        count: bus.out_count, empty: bus.out_empty});
      rec_cyc_q.push_back(cyc);
    end
  end

  task automatic send(input logic [127:0] km, input logic last);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_kmer  = km;
    bus.in_last  = last;
    last_beat_cyc = cyc + 1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_kmer  = '0;
    repeat (3) @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.out_min_hash !== 16'hFFFF) begin errors++; $display("FAIL reset_hash: got %h expected ffff", bus.out_min_hash); end
    checks++; if (bus.out_min_pos !== 6'd0) begin errors++; $display("FAIL reset_pos: got %0d expected 0", bus.out_min_pos); end
    checks++; if (bus.out_count !== 7'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus.out_count); end
    checks++; if (bus.out_empty !== 1'b0) begin errors++; $display("FAIL reset_empty: got %b expected 0", bus.out_empty); end
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_full_segment();
    mh_sketch_t exp;
    rec_q.delete(); rec_cyc_q.delete();
    for (int b = 0; b < 64; b++) send((b == 5) ? KM_A : KM_ACGT, 1'b0);
    idle(6);
    exp = '{hash: 16'h0000, pos: 6'd5, count: 7'd64, empty: 1'b0};
    checks++;
    if (rec_q.size() != 1) begin
      errors++; $display("FAIL full_seg_nrec: got %0d expected 1", rec_q.size());
    end else begin
      checks++; if (rec_q[0] !== exp) begin errors++; $display("FAIL full_seg_rec: got %h expected %h", rec_q[0], exp); end
      checks++; if (rec_cyc_q[0] != last_beat_cyc + 2) begin errors++; $display("FAIL full_seg_latency: got cycle %0d expected %0d", rec_cyc_q[0], last_beat_cyc + 2); end
    end
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_min_pos !== 6'd5 || bus.out_count !== 7'd64) begin
      errors++; $display("FAIL full_seg_hold: got v=%b pos=%0d cnt=%0d expected v=0 pos=5 cnt=64",
                         bus.out_valid, bus.out_min_pos, bus.out_count);
    end
  endtask

  task automatic test_early_last();
    mh_sketch_t exp[2];
    rec_q.delete(); rec_cyc_q.delete();
    for (int b = 0; b < 64; b++) send((b == 5) ? KM_A : KM_ACGT, (b == 9) || (b == 63));
    idle(6);
    exp[0] = '{hash: 16'h0000, pos: 6'd5, count: 7'd10, empty: 1'b0};
    exp[1] = '{hash: H_ACGT,   pos: 6'd0, count: 7'd54, empty: 1'b0};
    checks++;
    if (rec_q.size() != 2) begin
      errors++; $display("FAIL early_last_nrec: got %0d expected 2", rec_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (rec_q[i] !== exp[i]) begin errors++; $display("FAIL early_last_rec%0d: got %h expected %h", i, rec_q[i], exp[i]); end
      end
    end
  endtask

  task automatic test_bad_kmer();
    mh_sketch_t exp;
    rec_q.delete(); rec_cyc_q.delete();
    for (int b = 0; b < 3; b++) send(KM_N, b == 2);
    idle(6);
    exp = '{hash: 16'hFFFF, pos: 6'd0, count: 7'd3, empty: 1'b1};
    checks++;
    if (rec_q.size() != 1) begin
      errors++; $display("FAIL bad_kmer_nrec: got %0d expected 1", rec_q.size());
    end else begin
      checks++; if (rec_q[0] !== exp) begin errors++; $display("FAIL bad_kmer_rec: got %h expected %h", rec_q[0], exp); end
    end
  endtask

  task automatic test_tie();
    mh_sketch_t exp;
    rec_q.delete(); rec_cyc_q.delete();
    for (int b = 0; b < 10; b++) send((b == 2 || b == 7) ? KM_A : KM_ACGT, b == 9);
    idle(6);
    exp = '{hash: 16'h0000, pos: 6'd2, count: 7'd10, empty: 1'b0};
    checks++;
    if (rec_q.size() != 1) begin
      errors++; $display("FAIL tie_nrec: got %0d expected 1", rec_q.size());
    end else begin
      checks++; if (rec_q[0] !== exp) begin errors++; $display("FAIL tie_rec: got %h expected %h", rec_q[0], exp); end
    end
  endtask

  task automatic test_gaps();
    mh_sketch_t exp;
    rec_q.delete(); rec_cyc_q.delete();
    for (int b = 0; b < 64; b++) begin
      send((b == 40) ? KM_A : KM_ACGT, 1'b0);
      idle(1);
    end
    idle(6);
    exp = '{hash: 16'h0000, pos: 6'd40, count: 7'd64, empty: 1'b0};
    checks++;
    if (rec_q.size() != 1) begin
      errors++; $display("FAIL gaps_nrec: got %0d expected 1", rec_q.size());
    end else begin
      checks++; if (rec_q[0] !== exp) begin errors++; $display("FAIL gaps_rec: got %h expected %h", rec_q[0], exp); end
    end
  endtask

  task automatic test_reset_mid();
    mh_sketch_t exp;
    rec_q.delete(); rec_cyc_q.delete();
    for (int b = 0; b < 20; b++) send((b == 3) ? KM_A : KM_ACGT, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    for (int b = 0; b < 5; b++) send((b == 3) ? KM_A : KM_ACGT, b == 4);
    idle(6);
    exp = '{hash: 16'h0000, pos: 6'd3, count: 7'd5, empty: 1'b0};
    checks++;
    if (rec_q.size() != 1) begin
      errors++; $display("FAIL reset_mid_nrec: got %0d expected 1", rec_q.size());
    end else begin
      checks++; if (rec_q[0] !== exp) begin errors++; $display("FAIL reset_mid_rec: got %h expected %h", rec_q[0], exp); end
    end
  endtask

  task automatic test_back_to_back();
    mh_sketch_t exp[5];
    rec_q.delete(); rec_cyc_q.delete();
    send(KM_A, 1'b1);
    send(KM_ACGT, 1'b1);
    send(KM_N, 1'b1);
    send(KM_ACGT, 1'b0);
    send(KM_A, 1'b1);
    send(KM_A, 1'b0);
    send(KM_ACGT, 1'b1);
    idle(6);
    exp[0] = '{hash: 16'h0000, pos: 6'd0, count: 7'd1, empty: 1'b0};
    exp[1] = '{hash: H_ACGT,   pos: 6'd0, count: 7'd1, empty: 1'b0};
    exp[2] = '{hash: 16'hFFFF, pos: 6'd0, count: 7'd1, empty: 1'b1};
    exp[3] = '{hash: 16'h0000, pos: 6'd1, count: 7'd2, empty: 1'b0};
    exp[4] = '{hash: 16'h0000, pos: 6'd0, count: 7'd2, empty: 1'b0};
    checks++;
    if (rec_q.size() != 5) begin
      errors++; $display("FAIL b2b_nrec: got %0d expected 5", rec_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (rec_q[i] !== exp[i]) begin errors++; $display("FAIL b2b_rec%0d: got %h expected %h", i, rec_q[i], exp[i]); end
      end
      checks++;
      if (rec_cyc_q[2] != rec_cyc_q[0] + 2) begin
        errors++; $display("FAIL b2b_spacing: got cycles %0d..%0d expected consecutive", rec_cyc_q[0], rec_cyc_q[2]);
      end
    end
  endtask

  // Reference hash: 2-bit encode each byte, multiply mod 2^32, keep top 16.
  function automatic logic [15:0] ref_hash(input logic [127:0] km, output bit bad);
    logic [31:0] code;
    logic [31:0] prod;
    bad = 1'b0;
    code = '0;
    for (int i = 0; i < 16; i++) begin
      case (km[8*i +: 8])
        8'h41, 8'h61: code[2*i +: 2] = 2'd0;
        8'h43, 8'h63: code[2*i +: 2] = 2'd1;
        8'h47, 8'h67: code[2*i +: 2] = 2'd2;
        8'h54, 8'h74: code[2*i +: 2] = 2'd3;
        default:      bad = 1'b1;
      endcase
    end
    prod = code * 32'h9E3779B1;
    return prod[31:16];
  endfunction

  task automatic test_random();
    logic [7:0]   alph [8];
    mh_sketch_t   exp_q[$];
    logic [127:0] km;
    logic [15:0]  h, mn;
    logic         last;
    bit           bad, in_seg, seen;
    int           cnt, mpos, nbeats;
    alph = '{8'h41, 8'h43, 8'h47, 8'h54, 8'h61, 8'h63, 8'h67, 8'h74};
    rec_q.delete(); rec_cyc_q.delete();
    in_seg = 0; seen = 0; cnt = 0; mpos = 0; mn = '1;
    nbeats = 400;
    for (int n = 0; n < nbeats; n++) begin
      if ($urandom_range(0, 3) == 0 && n != nbeats - 1) begin
        idle(1);
        continue;
      end
      // Narrow alphabet so equal/small hashes actually occur.
      for (int i = 0; i < 16; i++) km[8*i +: 8] = alph[(i < 13) ? 0 : $urandom_range(0, 7)];
      if ($urandom_range(0, 9) == 0) km[8*$urandom_range(0, 15) +: 8] = 8'h4E;
      last = ($urandom_range(0, 19) == 0) || (n == nbeats - 1);
      send(km, last);
      h = ref_hash(km, bad);
      if (!in_seg) begin in_seg = 1; cnt = 0; seen = 0; mn = '1; mpos = 0; end
      if (!bad && (!seen || h < mn)) begin mn = h; mpos = cnt; seen = 1; end
      cnt++;
      if (last || cnt == 64) begin
        exp_q.push_back('{hash: mn, pos: 6'(mpos), count: 7'(cnt), empty: !seen});
        in_seg = 0;
      end
    end
    idle(6);
    checks++;
    if (rec_q.size() != exp_q.size()) begin
      errors++; $display("FAIL random_nrec: got %0d expected %0d", rec_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (rec_q[i] !== exp_q[i]) begin errors++; $display("FAIL random_rec%0d: got %h expected %h", i, rec_q[i], exp_q[i]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_segment();
    test_early_last();
    test_bad_kmer();
    test_tie();
    test_gaps();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
